// File: rtl/sys_array_sequencer.sv
// sys_array_sequencer: job sequencer for a SYS_ROWS x SYS_COLS systolic array.
// Each job runs cfg_tiles tiles; each tile preloads one weight row per cycle
// (LOAD_W), streams cfg_len activation vectors (COMPUTE), then waits for the
// array pipeline to empty (DRAIN). Result writes trail activation reads by
// LAT = SYS_ROWS + SYS_COLS - 1 cycles through a shift register.
// Optional feature: define SEQ_PERF_CNT_EN to add the 32-bit perf_cycles output.
module sys_array_sequencer #(
  parameter int SYS_ROWS = 6,
  parameter int SYS_COLS = 3,
  parameter int ADDR_W   = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [7:0]                  cfg_tiles,
  input  logic [7:0]                  cfg_len,
  output logic                        w_load_en,
  output logic [$clog2(SYS_ROWS)-1:0] w_row_sel,
  output logic [ADDR_W-1:0]           w_addr,
  output logic                        act_rd_en,
  output logic [ADDR_W-1:0]           act_addr,
  output logic                        res_wr_en,
  output logic [ADDR_W-1:0]           res_addr,
  output logic                        busy,
  output logic                        ready
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_cycles
`endif
);

  localparam int LAT   = SYS_ROWS + SYS_COLS - 1;
  localparam int ROW_W = $clog2(SYS_ROWS);
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [7:0]         tiles_left_q;
  logic [7:0]         len_q;
  logic [ADDR_W-1:0]  w_addr_q, act_addr_q, res_addr_q;
  logic [LAT-1:0]     dl_q;
  logic               job_start;
  logic               next_tile;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode from registered state and phase counter.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d   = state_q;
    w_load_en = 1'b0;
    act_rd_en = 1'b0;
    busy      = 1'b0;
    ready     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_load_en = 1'b1;
        busy      = 1'b1;
        if (cnt_q == CNT_W'(SYS_ROWS - 1)) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        act_rd_en = 1'b1;
        busy      = 1'b1;
        if (cnt_q == CNT_W'(len_q - 8'd1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(LAT - 1))
          state_d = (tiles_left_q > 8'd1) ? S_LOAD_W : S_DONE;
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort beats everything, including a pending start.
    if (abort) state_d = S_IDLE;
  end

  assign job_start = (state_q == S_IDLE)  && (state_d == S_LOAD_W);
  assign next_tile = (state_q == S_DRAIN) && (state_d == S_LOAD_W);

  // Phase counter, job configuration, buffer addresses and result delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the delay line is a handful of flops, not a RAM, so it is reset
      // along with everything else; stale bits would fire spurious writes.
      cnt_q        <= '0;
      tiles_left_q <= '0;
      len_q        <= '0;
      w_addr_q     <= '0;
      act_addr_q   <= '0;
      res_addr_q   <= '0;
      dl_q         <= '0;
    end else begin
      // Phase counter restarts on every state entry and idles at zero.
      if (state_d != state_q || state_q == S_IDLE) cnt_q <= '0;
      else                                         cnt_q <= cnt_q + CNT_W'(1);

      // An abort flushes in-flight results so no write follows it.
      if (abort && state_q != S_IDLE) dl_q <= '0;
      else                            dl_q <= {dl_q[LAT-2:0], act_rd_en};

      if (w_load_en) w_addr_q   <= w_addr_q   + ADDR_W'(1);
      if (act_rd_en) act_addr_q <= act_addr_q + ADDR_W'(1);
      if (res_wr_en) res_addr_q <= res_addr_q + ADDR_W'(1);

      if (next_tile) tiles_left_q <= tiles_left_q - 8'd1;

      // Addresses run on across tiles; only a new job rewinds them.
      if (job_start) begin
        tiles_left_q <= (cfg_tiles == 8'd0) ? 8'd1 : cfg_tiles;
        len_q        <= (cfg_len   == 8'd0) ? 8'd1 : cfg_len;
        w_addr_q     <= '0;
        act_addr_q   <= '0;
        res_addr_q   <= '0;
      end
    end
  end

  assign w_row_sel = (state_q == S_LOAD_W) ? cnt_q[ROW_W-1:0] : '0;
  assign w_addr    = w_addr_q;
  assign act_addr  = act_addr_q;
  assign res_addr  = res_addr_q;
  assign res_wr_en = dl_q[LAT-1];

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: cleared on job start, frozen once the job ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            perf_q <= '0;
    else if (job_start) perf_q <= '0;
    else if (busy)      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sys_array_sequencer.sv
// tb_sys_array_sequencer: directed and randomized jobs compared cycle by cycle
// against a schedule model that derives every output from tile period
// arithmetic (LOAD_W rows, then len reads, then LAT drain cycles per tile).
module tb_sys_array_sequencer;

  localparam int R   = 6;
  localparam int C   = 3;
  localparam int AW  = 10;
  localparam int LAT = R + C - 1;
  localparam int RW  = $clog2(R);

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [7:0]    cfg_tiles, cfg_len;
  logic          w_load_en, act_rd_en, res_wr_en, busy, ready;
  logic [RW-1:0] w_row_sel;
  logic [AW-1:0] w_addr, act_addr, res_addr;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]   perf_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sys_array_sequencer #(.SYS_ROWS(R), .SYS_COLS(C), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_tiles (cfg_tiles),
    .cfg_len   (cfg_len),
    .w_load_en (w_load_en),
    .w_row_sel (w_row_sel),
    .w_addr    (w_addr),
    .act_rd_en (act_rd_en),
    .act_addr  (act_addr),
    .res_wr_en (res_wr_en),
    .res_addr  (res_addr),
    .busy      (busy),
    .ready     (ready)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Row select only has meaning while a weight row is being loaded.
  function automatic logic [63:0] pack(input logic wl, input logic [RW-1:0] rs,
                                       input logic [AW-1:0] wa, input logic ar,
                                       input logic [AW-1:0] aa, input logic rw,
                                       input logic [AW-1:0] ra, input logic b,
                                       input logic rd);
    return 64'({wl, (wl ? rs : RW'(0)), wa, ar, aa, rw, ra, b, rd});
  endfunction

  function automatic logic [63:0] observed();
    return pack(w_load_en, w_row_sel, w_addr, act_rd_en, act_addr,
                res_wr_en, res_addr, busy, ready);
  endfunction

  // Launch one job and compare every cycle. abort_at / glitch_at / rst_at are
  // job cycle numbers (cycle 1 follows the accepting edge); 0 disables each.
  task automatic run_job(input logic [7:0] t_cfg, input logic [7:0] l_cfg,
                         input int abort_at, input int glitch_at, input int rst_at);
    int t, l, p, total, last;
    int res_obs, res_exp, rdy_obs, rdy_exp;
    logic [AW-1:0] ew, ea, er;
    t     = (t_cfg == 8'd0) ? 1 : int'(t_cfg);
    l     = (l_cfg == 8'd0) ? 1 : int'(l_cfg);
    p     = R + l + LAT;
    total = t * p;
    last  = (abort_at > 0) ? abort_at + 2 : total + 2;
    ew = '0; ea = '0; er = '0;
    res_obs = 0; res_exp = 0; rdy_obs = 0; rdy_exp = 0;

    cfg_tiles = t_cfg;
    cfg_len   = l_cfg;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    // Config is only latched at start; later changes must not matter.
    cfg_tiles = 8'($urandom);
    cfg_len   = 8'($urandom);

    for (int c = 1; c <= last; c++) begin
      bit act, e_wl, e_ar, e_rw, e_rdy;
      int o;
      act   = (abort_at == 0 || c <= abort_at) && c <= total;
      o     = (c - 1) % p;
      e_wl  = act && o < R;
      e_ar  = act && o >= R && o < R + l;
      e_rw  = act && o >= R + LAT;
      e_rdy = (abort_at == 0) && (c == total + 1);
      check($sformatf("job t%0d l%0d cyc%0d", t, l, c), observed(),
            pack(e_wl, RW'(o % R), ew, e_ar, ea, e_rw, er, act, e_rdy));
      res_obs += int'(res_wr_en);
      rdy_obs += int'(ready);
      res_exp += int'(e_rw);
      rdy_exp += int'(e_rdy);
      if (e_wl) ew = ew + AW'(1);
      if (e_ar) ea = ea + AW'(1);
      if (e_rw) er = er + AW'(1);
      if (c == glitch_at) start = 1'b1;
      if (c == abort_at)  abort = 1'b1;
      if (c == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check("async reset mid-cycle", observed(), 64'(0));
        start = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
    end
    check($sformatf("res pulses t%0d l%0d", t, l), 64'(res_obs), 64'(res_exp));
    check($sformatf("ready pulses t%0d l%0d", t, l), 64'(rdy_obs), 64'(rdy_exp));
`ifdef SEQ_PERF_CNT_EN
    check($sformatf("perf_cycles t%0d l%0d", t, l), 64'(perf_cycles),
          64'((abort_at > 0) ? abort_at : total));
`endif
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_tiles = 8'd0;
    cfg_len   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("outputs in reset", observed(), 64'(0));
    rst = 1'b0;

    // Start on the very first edge after reset release: one tile, four vectors.
    run_job(8'd1, 8'd4, 0, 0, 0);
    // Two tiles of two vectors: addresses carry across tiles.
    run_job(8'd2, 8'd2, 0, 0, 0);
    // Zero config behaves as one tile of one vector.
    run_job(8'd0, 8'd0, 0, 0, 0);
    // Abort during COMPUTE, then a fresh job must be accepted.
    run_job(8'd1, 8'd4, 9, 0, 0);
    run_job(8'd1, 8'd3, 0, 0, 0);
    // Start pulsed during COMPUTE is ignored; reset lands mid-DRAIN.
    run_job(8'd1, 8'd4, 0, 8, 13);
    repeat (2) @(posedge clk);
    #1;
    check("held in reset", observed(), 64'(0));
    rst = 1'b0;

    // Randomized jobs, some aborted somewhere inside the busy window.
    for (int j = 0; j < 6; j++) begin
      int tt, ll, tot, ab;
      tt  = int'($urandom_range(0, 3));
      ll  = int'($urandom_range(0, 10));
      tot = ((tt == 0) ? 1 : tt) * (R + ((ll == 0) ? 1 : ll) + LAT);
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, tot)) : 0;
      run_job(8'(tt), 8'(ll), ab, 0, 0);
    end

    // 170 tiles of 6 vectors precede the last tile: act_addr wraps 1023 -> 0.
    run_job(8'd171, 8'd6, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
